// File: rtl/dmac_pkg.sv
// Shared definitions for the single-channel DMA controller.
//   - slave register addresses
//   - FSM state encoding
//   - descriptor record held in the descriptor FIFO
package dmac_pkg;

    localparam int AW = 16;   // word address width
    localparam int SW = 16;   // descriptor size field width

    localparam logic [15:0] REG_OPSTART = 16'h0;
    localparam logic [15:0] REG_INT     = 16'h1;
    localparam logic [15:0] REG_INT_EN  = 16'h2;
    localparam logic [15:0] REG_SRC     = 16'h3;
    localparam logic [15:0] REG_DST     = 16'h4;
    localparam logic [15:0] REG_SIZE    = 16'h5;
    localparam logic [15:0] REG_PUSH    = 16'h6;
    localparam logic [15:0] REG_OPMODE  = 16'h7;
    localparam logic [15:0] REG_STATUS  = 16'h8;
    localparam logic [15:0] REG_OPCLEAR = 16'h9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_REQ,
        ST_READ,
        ST_LATCH,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [SW-1:0] size;
    } desc_t;

endpackage

// File: rtl/dmac_desc_fifo.sv
// Descriptor FIFO for the DMA controller.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_push / i_din  : enqueue a descriptor (dropped when full)
//   i_pop           : dequeue the head (ignored when empty)
//   i_flush         : empty the FIFO; wins over push/pop
//   o_head          : current head descriptor
//   o_full, o_empty : occupancy flags
//   o_count         : number of stored entries
module dmac_desc_fifo
    import dmac_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  desc_t         i_din,
    output desc_t         o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);

    desc_t         r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            // simultaneous push and pop leaves the count unchanged
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // storage needs no reset: the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (w_do_push && !reset && !i_flush) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/dmac_top.sv
// Single-channel DMA controller.
// Software stages descriptors through the slave port, pushes them into the
// descriptor FIFO and starts; the FSM copies each descriptor word by word
// (READ, LATCH, WRITE) over the master port and flags an interrupt once the
// FIFO has drained.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   m_grant, m_din      : bus grant, read data (valid the cycle after READ)
//   m_req, m_wr         : bus request, write strobe
//   m_addr, m_dout      : master address / write data (0 outside READ/WRITE)
//   s_sel, s_wr, s_addr : slave select, write/read, register address
//   s_din, s_dout       : slave write data, combinational read data
//   s_interrupt         : int_pending & int_en
module dmac_top
    import dmac_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int DESC_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_grant,
    input  logic [DATA_W-1:0] m_din,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    output logic [DATA_W-1:0] s_dout,
    output logic              s_interrupt
);

    localparam int CW = $clog2(DESC_DEPTH) + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_int_pending;
    logic              r_int_en;
    logic [ADDR_W-1:0] r_src_stg;
    logic [ADDR_W-1:0] r_dst_stg;
    logic [SW-1:0]     r_size_stg;
    logic [1:0]        r_opmode;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [SW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_chain;

    logic              w_wr;
    logic              w_start;
    logic              w_clear;
    logic              w_push;
    logic              w_int_clr;
    logic              w_pop;
    logic              w_set_int;
    logic              w_busy;
    desc_t             w_head;
    desc_t             w_new_desc;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_unused;

    assign w_wr       = s_sel & s_wr;
    assign w_start    = w_wr & (s_addr == REG_OPSTART) & s_din[0];
    assign w_clear    = w_wr & (s_addr == REG_OPCLEAR) & s_din[0];
    assign w_push     = w_wr & (s_addr == REG_PUSH)    & s_din[0];
    assign w_int_clr  = w_wr & (s_addr == REG_INT)     & s_din[0];
    assign w_busy     = (r_state != ST_IDLE);
    assign w_new_desc = '{src: r_src_stg, dst: r_dst_stg, size: r_size_stg};
    assign s_interrupt = r_int_pending & r_int_en;
    assign w_unused   = ^s_din[DATA_W-1:SW];

    dmac_desc_fifo #(.DEPTH(DESC_DEPTH), .CW(CW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_clear),
        .i_din   (w_new_desc),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        m_req       = 1'b0;
        m_wr        = 1'b0;
        m_addr      = '0;
        m_dout      = '0;
        w_pop       = 1'b0;
        w_set_int   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (!w_empty) w_state_nxt = ST_POP;
                    else          w_set_int   = 1'b1;
                end
            end
            ST_POP: begin
                // keep the bus between chained descriptors
                m_req       = r_chain;
                w_pop       = 1'b1;
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                m_req = 1'b1;
                if (r_cnt == '0)  w_state_nxt = ST_NEXT;
                else if (m_grant) w_state_nxt = ST_READ;
            end
            ST_READ: begin
                m_req = 1'b1;
                if (m_grant) begin
                    m_addr      = r_src;
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                m_req = 1'b1;
                if (m_grant) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                m_req = 1'b1;
                if (m_grant) begin
                    m_addr      = r_dst;
                    m_wr        = 1'b1;
                    m_dout      = r_data;
                    w_state_nxt = (r_cnt == SW'(1)) ? ST_NEXT : ST_READ;
                end
            end
            ST_NEXT: begin
                m_req       = 1'b1;
                w_state_nxt = w_empty ? ST_DONE : ST_POP;
            end
            ST_DONE: begin
                w_set_int   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_clear) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_int_pending <= 1'b0;
            r_int_en      <= 1'b0;
            r_src_stg     <= '0;
            r_dst_stg     <= '0;
            r_size_stg    <= '0;
            r_opmode      <= '0;
            r_src         <= '0;
            r_dst         <= '0;
            r_cnt         <= '0;
            r_data        <= '0;
            r_chain       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_chain <= (r_state == ST_NEXT);

            if (w_wr && s_addr == REG_INT_EN) r_int_en   <= s_din[0];
            if (w_wr && s_addr == REG_SRC)    r_src_stg  <= s_din[ADDR_W-1:0];
            if (w_wr && s_addr == REG_DST)    r_dst_stg  <= s_din[ADDR_W-1:0];
            if (w_wr && s_addr == REG_SIZE)   r_size_stg <= s_din[SW-1:0];
            if (w_wr && s_addr == REG_OPMODE) r_opmode   <= s_din[1:0];

            // a set in the same cycle as a software clear wins
            if (w_set_int)      r_int_pending <= 1'b1;
            else if (w_int_clr) r_int_pending <= 1'b0;

            if (r_state == ST_POP) begin
                r_src <= w_head.src;
                r_dst <= w_head.dst;
                r_cnt <= w_head.size;
            end
            if (r_state == ST_LATCH && m_grant) r_data <= m_din;
            if (r_state == ST_WRITE && m_grant) begin
                if (r_opmode[0]) r_src <= r_src + 1'b1;
                if (r_opmode[1]) r_dst <= r_dst + 1'b1;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        s_dout = '0;
        if (s_sel && !s_wr) begin
            case (s_addr)
                REG_OPSTART: s_dout[0]          = w_busy;
                REG_INT:     s_dout[0]          = r_int_pending;
                REG_INT_EN:  s_dout[0]          = r_int_en;
                REG_SRC:     s_dout[ADDR_W-1:0] = r_src_stg;
                REG_DST:     s_dout[ADDR_W-1:0] = r_dst_stg;
                REG_SIZE:    s_dout[SW-1:0]     = r_size_stg;
                REG_OPMODE:  s_dout[1:0]        = r_opmode;
                REG_STATUS:  s_dout[7:0]        = {4'(w_count), 2'b00, w_full, w_empty};
                default:     s_dout             = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmac_top.sv
module tb_dmac_top;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_grant;
    logic [31:0] m_din = '0;
    logic        s_sel;
    logic        s_wr;
    logic [15:0] s_addr;
    logic [31:0] s_din;
    logic        m_req;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_dout;
    logic [31:0] s_dout;
    logic        s_interrupt;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] q_rd [$];
    logic [47:0] q_wr [$];

    dmac_top #(.ADDR_W(16), .DATA_W(32), .DESC_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .m_grant(m_grant), .m_din(m_din),
        .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
        .s_dout(s_dout), .s_interrupt(s_interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Bus monitor / scoreboard. Memory model: a read of address A returns
    // A - 0x260 (0x300 -> 0xA0), held until the next read.
    always @(negedge clk) begin
        logic [47:0] e;
        if (!reset) begin
            if (m_wr) begin
                if (q_wr.size() == 0) flag("unexpected write");
                else begin
                    e = q_wr.pop_front();
                    chk("write addr", {16'h0, m_addr}, {16'h0, e[47:32]});
                    chk("write data", m_dout, e[31:0]);
                end
            end else if (m_addr != 16'h0) begin
                if (!m_req) flag("read without m_req");
                if (q_rd.size() == 0) flag("unexpected read");
                else chk("read addr", {16'h0, m_addr}, {16'h0, q_rd.pop_front()});
                m_din = {16'h0, m_addr} - 32'h260;
            end else if (m_dout != 32'h0) begin
                flag("m_dout outside write");
            end
        end
    end

    task automatic reg_wr(input logic [15:0] a, input logic [31:0] d);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
        @(negedge clk);
        s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [31:0] exp);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
        #1;
        chk(name, s_dout, exp);
        s_sel = 1'b0; s_addr = '0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            s_sel = 1'b1; s_wr = 1'b0; s_addr = 16'h0;
            #1;
            if (s_dout[0] == 1'b0) done = 1'b1;
            s_sel = 1'b0;
        end
        chk("idle within budget", {31'h0, done}, 32'h1);
    endtask

    task automatic push_desc(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] size);
        reg_wr(16'h3, {16'h0, src});
        reg_wr(16'h4, {16'h0, dst});
        reg_wr(16'h5, {16'h0, size});
        reg_wr(16'h6, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, rises, int_rises;
        logic prev_req, prev_int;
        bit found;

        // reset with an unmapped write held on the slave port
        reset = 1'b1; m_grant = 1'b0;
        s_sel = 1'b1; s_wr = 1'b1; s_addr = 16'hFFFF; s_din = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("reset m_req", {31'h0, m_req}, 32'h0);
        chk("reset m_wr", {31'h0, m_wr}, 32'h0);
        chk("reset m_addr", {16'h0, m_addr}, 32'h0);
        chk("reset m_dout", m_dout, 32'h0);
        chk("reset s_dout", s_dout, 32'h0);
        chk("reset s_interrupt", {31'h0, s_interrupt}, 32'h0);
        reset = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
        @(negedge clk);
        rd_chk("reset STATUS", 16'h8, 32'h01);
        rd_chk("reset OPSTART", 16'h0, 32'h0);

        // linear source to fixed destination, grant withheld for 4 cycles
        reg_wr(16'h2, 32'h1);
        push_desc(16'h300, 16'h103, 16'd8);
        reg_wr(16'h7, 32'h1);
        rd_chk("status one entry", 16'h8, 32'h10);
        for (int k = 0; k < 8; k++) begin
            q_rd.push_back(16'h300 + 16'(k));
            q_wr.push_back({16'h103, 32'hA0 + 32'(k)});
        end
        reg_wr(16'h0, 32'h1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("no grant m_req", {31'h0, m_req}, 32'h1);
            chk("no grant m_addr", {16'h0, m_addr}, 32'h0);
            @(negedge clk);
        end
        m_grant = 1'b1;
        wait_idle(60);
        chk("t1 reads drained", q_rd.size(), 0);
        chk("t1 writes drained", q_wr.size(), 0);
        chk("t1 m_req low", {31'h0, m_req}, 32'h0);
        repeat (3) @(negedge clk);
        chk("t1 interrupt held", {31'h0, s_interrupt}, 32'h1);
        rd_chk("t1 INT read", 16'h1, 32'h1);
        reg_wr(16'h1, 32'h1);
        chk("t1 interrupt cleared", {31'h0, s_interrupt}, 32'h0);

        // two chained descriptors, both addresses increment
        reg_wr(16'h7, 32'h3);
        push_desc(16'h310, 16'h200, 16'd2);
        push_desc(16'h320, 16'h210, 16'd1);
        q_rd.push_back(16'h310); q_rd.push_back(16'h311); q_rd.push_back(16'h320);
        q_wr.push_back({16'h200, 32'hB0});
        q_wr.push_back({16'h201, 32'hB1});
        q_wr.push_back({16'h210, 32'hC0});
        reg_wr(16'h0, 32'h1);
        hi = 0; rises = 0; int_rises = 0; prev_req = 1'b0; prev_int = s_interrupt;
        for (int i = 0; i < 25; i++) begin
            if (m_req) hi++;
            if (m_req && !prev_req) rises++;
            if (s_interrupt && !prev_int) int_rises++;
            prev_req = m_req; prev_int = s_interrupt;
            @(negedge clk);
        end
        chk("t2 m_req cycles", hi, 14);
        chk("t2 m_req continuous", rises, 1);
        chk("t2 single interrupt", int_rises, 1);
        chk("t2 writes drained", q_wr.size(), 0);
        reg_wr(16'h1, 32'h1);

        // grant dropped for 3 cycles while in LATCH
        push_desc(16'h330, 16'h220, 16'd2);
        q_rd.push_back(16'h330); q_rd.push_back(16'h331);
        q_wr.push_back({16'h220, 32'hD0});
        q_wr.push_back({16'h221, 32'hD1});
        reg_wr(16'h0, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_addr == 16'h330 && !m_wr) found = 1'b1;
            else @(negedge clk);
        end
        chk("t3 first read seen", {31'h0, found}, 32'h1);
        @(negedge clk);
        m_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3 hold m_wr", {31'h0, m_wr}, 32'h0);
            chk("t3 hold m_addr", {16'h0, m_addr}, 32'h0);
            chk("t3 hold m_req", {31'h0, m_req}, 32'h1);
        end
        m_grant = 1'b1;
        wait_idle(30);
        chk("t3 reads drained", q_rd.size(), 0);
        chk("t3 writes drained", q_wr.size(), 0);
        reg_wr(16'h1, 32'h1);

        // FIFO full: fifth push dropped; SIZE=0 descriptors move no data
        reg_wr(16'h3, 32'h350);
        reg_wr(16'h4, 32'h240);
        reg_wr(16'h5, 32'h0);
        for (int i = 0; i < 5; i++) reg_wr(16'h6, 32'h1);
        rd_chk("t4 STATUS full", 16'h8, 32'h42);
        reg_wr(16'h0, 32'h1);
        wait_idle(40);
        chk("t4 interrupt", {31'h0, s_interrupt}, 32'h1);
        rd_chk("t4 STATUS empty", 16'h8, 32'h01);
        reg_wr(16'h1, 32'h1);

        // OPCLEAR while requesting the bus
        m_grant = 1'b0;
        push_desc(16'h360, 16'h250, 16'd4);
        reg_wr(16'h6, 32'h1);
        reg_wr(16'h0, 32'h1);
        @(negedge clk);
        chk("t5 m_req before clear", {31'h0, m_req}, 32'h1);
        reg_wr(16'h9, 32'h1);
        chk("t5 m_req after clear", {31'h0, m_req}, 32'h0);
        rd_chk("t5 STATUS flushed", 16'h8, 32'h01);
        rd_chk("t5 busy", 16'h0, 32'h0);
        rd_chk("t5 INT", 16'h1, 32'h0);
        m_grant = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5 stays idle", {31'h0, m_req}, 32'h0);
        chk("t5 no interrupt", {31'h0, s_interrupt}, 32'h0);

        // start with an empty FIFO raises the interrupt directly
        reg_wr(16'h0, 32'h1);
        rd_chk("empty start INT", 16'h1, 32'h1);
        rd_chk("empty start busy", 16'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
